// File: rtl/utopia1_rx_arbiter.sv
// Utopia-1 receive scheduler: round-robin cell-level polling of NPORT PHYs, one 53-byte cell at a time.
// States: IDLE pick port | XFER enable low 53 edges | DRAIN last byte | GAP let PHY refresh clav.
module utopia1_rx_arbiter #(
  parameter int NPORT = 4,
  parameter int PW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NPORT-1:0]   phy_clav,
  input  logic [NPORT-1:0]   phy_soc,
  input  logic [8*NPORT-1:0] phy_data,
  output logic [NPORT-1:0]   phy_en_n,
  input  logic               sink_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_soc,
  output logic               out_eoc,
  output logic [PW-1:0]      out_port,
  output logic               out_abort,
  output logic               err_soc
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [5:0]    cnt;
  logic [PW-1:0] nxt;
  logic          found;
  logic [7:0]    sel_byte;
  logic          sel_soc;

  // The pointer doubles as the current grant while a cell is in flight.
  assign sel_byte = phy_data[{ptr, 3'b000} +: 8];
  assign sel_soc  = phy_soc[ptr];

  // Scan downward so the candidate closest to ptr+1 is the one left standing.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_w;
    found = 1'b0;
    nxt   = '0;
    idx   = 0;
    idx_w = '0;
    for (int i = NPORT; i >= 1; i--) begin
      idx   = (int'(ptr) + i) % NPORT;
      idx_w = PW'(idx);
      if (phy_clav[idx_w]) begin
        found = 1'b1;
        nxt   = idx_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= PW'(NPORT - 1);
      cnt       <= '0;
      phy_en_n  <= '1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_soc   <= 1'b0;
      out_eoc   <= 1'b0;
      out_port  <= '0;
      out_abort <= 1'b0;
      err_soc   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_soc   <= 1'b0;
      out_eoc   <= 1'b0;
      out_abort <= 1'b0;
      err_soc   <= 1'b0;
      case (state)
        IDLE: begin
          if (sink_ready && found) begin
            ptr      <= nxt;
            phy_en_n <= ~(NPORT'(1) << nxt);
            cnt      <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd52) begin
            phy_en_n <= '1;
            state    <= DRAIN;
          end
          // cnt is the number of the byte arriving this edge (0 = none yet).
          if (cnt != 6'd0) begin
            if (cnt == 6'd1 && !sel_soc) begin
              err_soc   <= 1'b1;
              out_abort <= 1'b1;
              phy_en_n  <= '1;
              state     <= GAP;
            end else begin
              out_valid <= 1'b1;
              out_data  <= sel_byte;
              out_port  <= ptr;
              out_soc   <= (cnt == 6'd1);
              err_soc   <= (cnt != 6'd1) && sel_soc;
            end
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_data  <= sel_byte;
          out_port  <= ptr;
          out_eoc   <= 1'b1;
          err_soc   <= sel_soc;
          state     <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utopia1_rx_arbiter.sv
// Scoreboard bench for utopia1_rx_arbiter: PHY byte model, expected-beat queue, directed scenarios.
module tb_utopia1_rx_arbiter;

  localparam int NPORT = 4;
  localparam int PW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NPORT-1:0]  phy_clav = '0;
  logic [NPORT-1:0]  phy_soc;
  logic [8*NPORT-1:0] phy_data;
  logic [NPORT-1:0]  phy_en_n;
  logic              sink_ready = 1'b0;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_soc;
  logic              out_eoc;
  logic [PW-1:0]     out_port;
  logic              out_abort;
  logic              err_soc;

  utopia1_rx_arbiter #(.NPORT(NPORT), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .phy_clav(phy_clav), .phy_soc(phy_soc),
    .phy_data(phy_data), .phy_en_n(phy_en_n), .sink_ready(sink_ready),
    .out_valid(out_valid), .out_data(out_data), .out_soc(out_soc),
    .out_eoc(out_eoc), .out_port(out_port), .out_abort(out_abort),
    .err_soc(err_soc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PHY model: presents byte k after the k-th edge at which its enable was low.
  int         bidx[NPORT];
  logic [7:0] base[NPORT];
  logic [NPORT-1:0] bad_first = '0;
  int         stray[NPORT];
  logic [NPORT-1:0] prev_en = '1;

  always @(negedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (!prev_en[p]) bidx[p] = bidx[p] + 1;
      else if (!phy_en_n[p]) bidx[p] = 0;
    end
    prev_en = phy_en_n;
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      phy_data[8*p +: 8] = base[p] + 8'(bidx[p] - 1);
      phy_soc[p] = ((bidx[p] == 1) && !bad_first[p]) || (bidx[p] == stray[p]);
    end
  end

  typedef struct {
    logic       abort;
    logic [1:0] port;
    logic [7:0] data;
    logic       soc;
    logic       eoc;
  } exp_t;

  exp_t q[$];
  int   err_seen = 0;

  task automatic push_cell(input int p, input int nbytes);
    exp_t e;
    for (int k = 1; k <= nbytes; k++) begin
      e.abort = 1'b0;
      e.port  = 2'(p);
      e.data  = base[p] + 8'(k - 1);
      e.soc   = (k == 1);
      e.eoc   = (k == 53);
      q.push_back(e);
    end
  endtask

  task automatic push_abort(input int p);
    exp_t e;
    e.abort = 1'b1;
    e.port  = 2'(p);
    e.data  = '0;
    e.soc   = 1'b0;
    e.eoc   = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per presented beat or abort.
  always @(negedge clk) begin
    exp_t e;
    chk("en_onehot", 32'(($countones(~phy_en_n) <= 1)), 32'd1);
    if (rst_n) begin
      if (err_soc) err_seen++;
      if (out_valid || out_abort) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {out_abort, out_valid, 6'b0, out_data}, 32'd0);
        end else begin
          e = q.pop_front();
          if (e.abort)
            chk("abort_beat", {out_abort, out_valid, err_soc}, 3'b101);
          else
            chk("cell_beat", {out_abort, out_valid, out_port, out_data, out_soc, out_eoc},
                {1'b0, 1'b1, e.port, e.data, e.soc, e.eoc});
        end
      end
    end
  end

  task automatic wait_grant(output int port, output int at);
    port = -1;
    at   = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (phy_en_n != '1) begin
        for (int p = 0; p < NPORT; p++) if (!phy_en_n[p]) port = p;
        at = cyc;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      if (phy_en_n == '1) return;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(phy_en_n), 32'hF);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  int g, c1, c2, n;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    base[0] = 8'h40; base[1] = 8'h80; base[2] = 8'h00; base[3] = 8'hC0;
    for (int p = 0; p < NPORT; p++) begin
      bidx[p]  = 0;
      stray[p] = -1;
    end
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(phy_en_n), 32'hF);
    chk("rst_outs", {out_valid, out_soc, out_eoc, out_abort, err_soc, out_data, out_port}, 32'd0);
    rst_n = 1'b1;

    // Single port 2, then a back-to-back second cell to measure the period.
    sink_ready = 1'b1;
    push_cell(2, 53);
    phy_clav = 4'b0100;
    wait_grant(g, c1);
    chk("t1_port", 32'(g), 32'd2);
    chk("t1_en", 32'(phy_en_n), 32'hB);
    push_cell(2, 53);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (phy_en_n == 4'b1011) n++;
      else break;
    end
    chk("t1_en_len", 32'(n), 32'd53);
    wait_grant(g, c2);
    phy_clav = '0;
    chk("t1_port2", 32'(g), 32'd2);
    chk("t1_period", 32'(c2 - c1), 32'd56);
    wait_idle();
    wait_drain();

    // Backpressure on port 3.
    sink_ready = 1'b0;
    phy_clav   = 4'b1000;
    push_cell(3, 53);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'(phy_en_n), 32'hF);
    end
    sink_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant", 32'(phy_en_n), 32'h7);
    phy_clav = '0;
    repeat (10) @(negedge clk);
    sink_ready = 1'b0;
    wait_idle();
    wait_drain();

    // Round robin with all ports requesting; pointer now at 3.
    for (int i = 0; i < 5; i++) push_cell(rr_exp[i], 53);
    sink_ready = 1'b1;
    phy_clav   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, c1);
      chk("rr_port", 32'(g), 32'(rr_exp[i]));
      if (i == 4) phy_clav = '0;
      wait_idle();
    end
    wait_drain();

    // Missing SOC on port 1, then port 2 must win over port 1.
    bad_first[1] = 1'b1;
    push_abort(1);
    phy_clav = 4'b0010;
    wait_grant(g, c1);
    chk("ms_port", 32'(g), 32'd1);
    @(negedge clk);
    chk("ms_en_e1", 32'(phy_en_n), 32'hD);
    @(negedge clk);
    chk("ms_en_e2", 32'(phy_en_n), 32'hF);
    bad_first[1] = 1'b0;
    push_cell(2, 53);
    phy_clav = 4'b0110;
    wait_grant(g, c1);
    phy_clav = '0;
    chk("ms_next_port", 32'(g), 32'd2);
    wait_idle();
    wait_drain();
    chk("ms_err_count", 32'(err_seen), 32'd1);

    // Stray SOC on byte 20 of port 3.
    stray[3] = 20;
    push_cell(3, 53);
    phy_clav = 4'b1000;
    wait_grant(g, c1);
    phy_clav = '0;
    chk("stray_port", 32'(g), 32'd3);
    wait_idle();
    wait_drain();
    stray[3] = -1;
    chk("stray_err_count", 32'(err_seen), 32'd2);

    // Reset while byte 30 is being received on port 2.
    push_cell(2, 29);
    phy_clav = 4'b0100;
    wait_grant(g, c1);
    phy_clav = '0;
    chk("rst_cell_port", 32'(g), 32'd2);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'(phy_en_n), 32'hF);
    chk("rst_mid_valid", {out_valid, out_eoc, out_abort}, 32'd0);
    chk("rst_mid_queue", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_cell(0, 53);
    phy_clav = 4'b0101;
    wait_grant(g, c1);
    phy_clav = '0;
    chk("post_rst_port", 32'(g), 32'd0);
    wait_idle();
    wait_drain();

    chk("final_queue", 32'(q.size()), 32'd0);
    chk("final_err_count", 32'(err_seen), 32'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
